// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial bus arbiter.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGranted,
    StRelease
  } arb_state_t;

  localparam int unsigned DefaultTimeout = 64;

  // Width of an index into n masters; never below one bit.
  function automatic int unsigned owner_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping to bit 0.
module rr_priority_picker
  import serial_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IdxW        = owner_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IdxW-1:0]        ptr,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IdxW-1:0]        winner_idx,
  output logic                   valid
);

  logic [IdxW:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, ptr} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(NUM_MASTERS)) begin
        cand = cand - (IdxW + 1)'(NUM_MASTERS);
      end
      if (!valid && req[cand[IdxW-1:0]]) begin
        valid      = 1'b1;
        winner_idx = cand[IdxW-1:0];
      end
    end
    if (valid) begin
      winner[winner_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter multiplexing several serial-bus masters onto one slave port,
// with a turnaround cycle between owners and a watchdog that reclaims a hung bus.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS-1:0]                m_req,
  input  logic [NUM_MASTERS-1:0]                m_mode,
  input  logic [NUM_MASTERS-1:0]                m_wr_bus,
  input  logic [NUM_MASTERS-1:0]                m_valid,
  input  logic [NUM_MASTERS-1:0]                m_ready,
  output logic [NUM_MASTERS-1:0]                m_grant,
  output logic [NUM_MASTERS-1:0]                m_rd_bus,
  output logic [NUM_MASTERS-1:0]                m_slave_ready,
  output logic [NUM_MASTERS-1:0]                m_slave_valid,
  output logic                                  s_mode,
  output logic                                  s_wr_bus,
  output logic                                  s_master_valid,
  output logic                                  s_master_ready,
  input  logic                                  s_rd_bus,
  input  logic                                  s_slave_ready,
  input  logic                                  s_slave_valid,
  output logic                                  busy,
  output logic [owner_width(NUM_MASTERS)-1:0]   owner,
  output logic                                  timeout
);

  localparam int unsigned IdxW  = owner_width(NUM_MASTERS);
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [WdogW-1:0]       wdog_q, wdog_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IdxW        (IdxW)
  ) u_picker (
    .req        (m_req),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGranted;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          wdog_d  = '0;
        end
      end
      StGranted: begin
        // A voluntary release wins over a coincident watchdog expiry.
        if (!m_req[owner_q]) begin
          state_d = StRelease;
          grant_d = '0;
        end else if (wdog_q == WdogLast) begin
          state_d   = StRelease;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StRelease: begin
        state_d = StIdle;
        ptr_d   = (owner_q == IdxLast) ? '0 : owner_q + IdxW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Grant is one-hot or zero, so AND-OR selection is a clean mux that idles at 0.
  assign s_mode         = |(m_mode & grant_q);
  assign s_wr_bus       = |(m_wr_bus & grant_q);
  assign s_master_valid = |(m_valid & grant_q);
  assign s_master_ready = |(m_ready & grant_q);

  assign m_rd_bus      = grant_q & {NUM_MASTERS{s_rd_bus}};
  assign m_slave_ready = grant_q & {NUM_MASTERS{s_slave_ready}};
  assign m_slave_valid = grant_q & {NUM_MASTERS{s_slave_valid}};

  assign m_grant = grant_q;
  assign busy    = (state_q == StGranted);
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: directed arbitration scenarios, an end-to-end
// transfer through a small serial slave, and a per-cycle reference model.
module tb_serial_bus_arbiter;

  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] m_req, m_mode, m_wr_bus, m_valid, m_ready;
  logic [1:0] m_grant, m_rd_bus, m_slave_ready, m_slave_valid;
  logic       s_mode, s_wr_bus, s_master_valid, s_master_ready;
  logic       s_rd_bus, s_slave_ready, s_slave_valid;
  logic       busy, owner, timeout;

  // Directed drive of the slave-side inputs, or the slave model when enabled.
  logic d_rd, d_srdy, d_sval, slave_en, sl_rd, sl_val;
  assign s_rd_bus      = slave_en ? sl_rd : d_rd;
  assign s_slave_ready = slave_en ? 1'b1 : d_srdy;
  assign s_slave_valid = slave_en ? sl_val : d_sval;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_bus_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m_req          (m_req),
    .m_mode         (m_mode),
    .m_wr_bus       (m_wr_bus),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_grant        (m_grant),
    .m_rd_bus       (m_rd_bus),
    .m_slave_ready  (m_slave_ready),
    .m_slave_valid  (m_slave_valid),
    .s_mode         (s_mode),
    .s_wr_bus       (s_wr_bus),
    .s_master_valid (s_master_valid),
    .s_master_ready (s_master_ready),
    .s_rd_bus       (s_rd_bus),
    .s_slave_ready  (s_slave_ready),
    .s_slave_valid  (s_slave_valid),
    .busy           (busy),
    .owner          (owner),
    .timeout        (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase 0 = free, 1 = owned, 2 = turnaround gap.
  int   ph = 0;
  int   held = 0;
  logic mo = 1'b0;
  logic mptr = 1'b0;
  logic mto = 1'b0;

  task automatic model_step;
    logic c;
    if (rst) begin
      ph = 0; held = 0; mo = 1'b0; mptr = 1'b0; mto = 1'b0;
      return;
    end
    mto = 1'b0;
    case (ph)
      0: begin
        for (int k = 0; k < 2; k++) begin
          c = mptr ^ k[0];
          if (ph == 0 && m_req[c]) begin
            mo = c; ph = 1; held = 1;
          end
        end
      end
      1: begin
        if (!m_req[mo]) ph = 2;
        else if (held == TO) begin ph = 2; mto = 1'b1; end
        else held++;
      end
      default: begin
        mptr = ~mo;
        ph = 0;
      end
    endcase
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin : compare_proc
    logic on;
    @(posedge clk);
    forever begin
      @(negedge clk);
      on = (ph == 1);
      chk("model grant", 32'(m_grant), on ? (mo ? 2 : 1) : 0);
      chk("model busy", 32'(busy), 32'(on));
      chk("model owner", 32'(owner), 32'(mo));
      chk("model timeout", 32'(timeout), 32'(mto));
      chk("model s_mode", 32'(s_mode), on ? 32'(m_mode[mo]) : 0);
      chk("model s_wr_bus", 32'(s_wr_bus), on ? 32'(m_wr_bus[mo]) : 0);
      chk("model s_master_valid", 32'(s_master_valid), on ? 32'(m_valid[mo]) : 0);
      chk("model s_master_ready", 32'(s_master_ready), on ? 32'(m_ready[mo]) : 0);
      chk("model m_rd_bus", 32'(m_rd_bus), on ? (32'(s_rd_bus) << mo) : 0);
      chk("model m_slave_ready", 32'(m_slave_ready), on ? (32'(s_slave_ready) << mo) : 0);
      chk("model m_slave_valid", 32'(m_slave_valid), on ? (32'(s_slave_valid) << mo) : 0);
    end
  end

  // Serial slave: 16 address bits MSB first, then 8 write bits (mode 1) or
  // 8 read bits returned on rd_bus with slave_valid (mode 0).
  logic [7:0] mem [16];

  initial begin : slave_proc
    logic [23:0] sh;
    logic [7:0]  q;
    int          cnt;
    sh = '0; cnt = 0; sl_rd = 1'b0; sl_val = 1'b0;
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
    forever begin
      @(posedge clk);
      if (slave_en && s_master_valid) begin
        sh = {sh[22:0], s_wr_bus};
        cnt++;
        if (s_mode && cnt == 24) begin
          mem[sh[11:8]] = sh[7:0];
          cnt = 0;
        end else if (!s_mode && cnt == 16) begin
          q = mem[sh[3:0]];
          cnt = 0;
          for (int b = 0; b < 8; b++) begin
            #1;
            sl_val = 1'b1;
            sl_rd  = q[7];
            q      = q << 1;
            @(posedge clk);
          end
          #1;
          sl_val = 1'b0;
          sl_rd  = 1'b0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_grant(input logic i);
    int n = 0;
    while (!m_grant[i] && n < 50) begin
      tick();
      n++;
    end
    chk("grant wait", 32'(m_grant[i]), 1);
  endtask

  task automatic m_write(input logic i, input logic [15:0] a, input logic [7:0] d);
    logic [23:0] f;
    f = {a, d};
    m_req[i] = 1'b1;
    tick();
    wait_grant(i);
    for (int b = 0; b < 24; b++) begin
      m_mode[i]   = 1'b1;
      m_valid[i]  = 1'b1;
      m_wr_bus[i] = f[23];
      f = f << 1;
      tick();
    end
    m_valid[i] = 1'b0; m_wr_bus[i] = 1'b0; m_mode[i] = 1'b0; m_req[i] = 1'b0;
  endtask

  task automatic m_read(input logic i, input logic [15:0] a, output logic [7:0] got);
    logic [15:0] f;
    int          n;
    f = a; got = '0; n = 0;
    m_req[i] = 1'b1;
    tick();
    wait_grant(i);
    for (int b = 0; b < 16; b++) begin
      m_mode[i]   = 1'b0;
      m_valid[i]  = 1'b1;
      m_wr_bus[i] = f[15];
      f = f << 1;
      tick();
    end
    m_valid[i] = 1'b0; m_wr_bus[i] = 1'b0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge clk);
      chk("e2e other master rd quiet", 32'(m_rd_bus[~i]), 0);
      if (m_slave_valid[i]) begin
        got = {got[6:0], m_rd_bus[i]};
        n++;
      end
    end
    chk("e2e read bit count", n, 8);
    tick();
    m_req[i] = 1'b0;
  endtask

  initial begin : main
    logic [7:0] rd;
    rst = 1'b1; m_req = '0; m_mode = '0; m_wr_bus = '0; m_valid = '0; m_ready = '0;
    d_rd = 1'b0; d_srdy = 1'b0; d_sval = 1'b0; slave_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset grant", 32'(m_grant), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset owner", 32'(owner), 0);
    chk("reset timeout", 32'(timeout), 0);

    // Lone request from master 1, plus routing in both directions.
    m_req = 2'b10; m_wr_bus = 2'b10;
    tick();
    chk("m1 grant", 32'(m_grant), 2);
    chk("m1 busy", 32'(busy), 1);
    chk("m1 owner", 32'(owner), 1);
    chk("m1 s_wr_bus high", 32'(s_wr_bus), 1);
    m_wr_bus = 2'b00; #1;
    chk("m1 s_wr_bus low", 32'(s_wr_bus), 0);
    d_sval = 1'b1; d_rd = 1'b1; #1;
    chk("m1 slave_valid route", 32'(m_slave_valid), 2);
    chk("m1 rd_bus high", 32'(m_rd_bus), 2);
    d_rd = 1'b0; #1;
    chk("m1 rd_bus low", 32'(m_rd_bus), 0);
    d_sval = 1'b0;
    m_req = 2'b00;
    tick();
    chk("m1 release grant", 32'(m_grant), 0);
    chk("m1 release busy", 32'(busy), 0);
    chk("m1 release owner kept", 32'(owner), 1);
    tick();

    // Both request: master 0 first, then master 1 after a two-cycle gap.
    m_req = 2'b11;
    tick();
    chk("both grant m0", 32'(m_grant), 1);
    repeat (4) tick();
    chk("m0 held 5", 32'(m_grant), 1);
    m_req = 2'b10;
    tick();
    chk("gap cycle 1", 32'(m_grant), 0);
    tick();
    chk("gap cycle 2", 32'(m_grant), 0);
    tick();
    chk("m1 after gap", 32'(m_grant), 2);

    // Watchdog: master 0 holds for the full window while master 1 waits.
    m_req = 2'b01;
    tick(); tick(); tick();
    chk("m0 regrant", 32'(m_grant), 1);
    m_req = 2'b11;
    repeat (TO - 1) tick();
    chk("m0 last held cycle", 32'(m_grant), 1);
    chk("no timeout yet", 32'(timeout), 0);
    tick();
    chk("timeout grant drop", 32'(m_grant), 0);
    chk("timeout pulse", 32'(timeout), 1);
    tick();
    chk("timeout one cycle", 32'(timeout), 0);
    tick();
    chk("m1 after timeout", 32'(m_grant), 2);

    // Request drop on the expiry cycle is an ordinary release.
    repeat (TO - 1) tick();
    m_req = 2'b01;
    tick();
    chk("drop at expiry grant", 32'(m_grant), 0);
    chk("drop at expiry no timeout", 32'(timeout), 0);
    tick(); tick();
    chk("m0 next", 32'(m_grant), 1);

    // Reset while owned.
    m_req = 2'b11; m_mode = 2'b11; m_wr_bus = 2'b11; m_valid = 2'b11; m_ready = 2'b11;
    tick();
    chk("pre-reset s_master_valid", 32'(s_master_valid), 1);
    rst = 1'b1;
    tick();
    chk("midreset grant", 32'(m_grant), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset owner", 32'(owner), 0);
    chk("midreset s_outputs", 32'({s_mode, s_wr_bus, s_master_valid, s_master_ready}), 0);
    rst = 1'b0; m_req = '0; m_mode = '0; m_wr_bus = '0; m_valid = '0; m_ready = '0;
    tick(); tick();

    // End to end: master 0 writes, master 1 reads the same address.
    slave_en = 1'b1;
    m_write(1'b0, 16'h0003, 8'hA5);
    tick(); tick();
    m_read(1'b1, 16'h0003, rd);
    chk("e2e read data", 32'(rd), 32'h A5);
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog_proc
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
